// File: rtl/serial_to_parallel_pkg.sv
// Shared constants for the serial_to_parallel deserializer.
// Holds the FSM encodings and the counter-width helper.
package serial_to_parallel_pkg;

  localparam int DEFAULT_WIDTH = 32'sd8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // Smallest r with 2**r >= value; sizes bit_count.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial input and parallel output handshake of the deserializer.
// slave is the deserializer side, master is the producer/consumer side.
interface serial_to_parallel_if
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  localparam int CW = clog2(WIDTH);

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    bit_count;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_data, out_valid, bit_count
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_data, out_valid, bit_count
  );
endinterface

// File: rtl/serial_to_parallel_shift_core.sv
// sipo_shift_core: shift register and bit counter with bit-order steering.
// word is the assembled word including the bit presented this cycle.
module sipo_shift_core
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             sync_clear,
  input  logic             shift_en,
  input  logic             in_bit,
  output logic [CW-1:0]    bit_count,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    count_r;

  // Steer the incoming bit into the low or high end of the word.
  always_comb begin
    word = '0;
    if (MSB_FIRST) begin
      word = {shift_r[WIDTH-2:0], in_bit};
    end else begin
      word = {in_bit, shift_r[WIDTH-1:1]};
    end
  end

  assign word_done = shift_en && (count_r == LAST);
  assign bit_count = count_r;

  // Shift state: clears when a word completes, holds on gaps.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shift_r <= '0;
      count_r <= '0;
    end else if (sync_clear) begin
      shift_r <= '0;
      count_r <= '0;
    end else if (word_done) begin
      shift_r <= '0;
      count_r <= '0;
    end else if (shift_en) begin
      shift_r <= word;
      count_r <= count_r + CW'(1);
    end else begin
      shift_r <= shift_r;
      count_r <= count_r;
    end
  end
endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer top: one-entry output buffer, valid/ready handshake and FSM.
// in_ready depends only on registered state, never on out_ready.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                sync_clear,
  serial_to_parallel_if.slave bus
);
  localparam int            CW     = clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic             word_done_s;
  logic [WIDTH-1:0] word_s;
  logic [CW-1:0]    bit_count_s;
  logic             valid_nxt_s;
  logic             last_slot_nxt_s;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;

  assign in_ready_s = !((bit_count_s == LAST) && out_valid_r);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign drain_s    = out_valid_r && bus.out_ready;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk        (clk),
    .clear_n    (clear_n),
    .sync_clear (sync_clear),
    .shift_en   (accept_s),
    .in_bit     (bus.in_bit),
    .bit_count  (bit_count_s),
    .word_done  (word_done_s),
    .word       (word_s)
  );

  // Output buffer: load on word completion, drop valid on drain.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (sync_clear) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else if (word_done_s) begin
      out_data_r  <= word_s;
      out_valid_r <= 1'b1;
    end else if (drain_s) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Next state tracks the post-edge bit_count/out_valid decode.
  always_comb begin
    valid_nxt_s     = out_valid_r;
    last_slot_nxt_s = 1'b0;
    state_nxt_s     = state_r;
    if (word_done_s) begin
      valid_nxt_s = 1'b1;
    end else if (drain_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = out_valid_r;
    end
    if (accept_s) begin
      last_slot_nxt_s = (bit_count_s == PENULT);
    end else begin
      last_slot_nxt_s = (bit_count_s == LAST);
    end
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (last_slot_nxt_s && valid_nxt_s) ? S_STALL : S_SHIFT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (word_done_s) begin
          state_nxt_s = S_IDLE;
        end else if (last_slot_nxt_s && valid_nxt_s) begin
          state_nxt_s = S_STALL;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      S_STALL: begin
        if (drain_s) begin
          state_nxt_s = S_SHIFT;
        end else begin
          state_nxt_s = S_STALL;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= S_IDLE;
    end else if (sync_clear) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bit_count = bit_count_s;
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench: MSB-first (dut_a) and LSB-first (dut_b) deserializers
// side by side, fed identical serial streams.
module tb_serial_to_parallel;
  import serial_to_parallel_pkg::*;

  logic clk        = 1'b0;
  logic clear_n    = 1'b0;
  logic sc_a       = 1'b0;
  logic sc_b       = 1'b0;
  int   n_cmp      = 0;
  int   n_bad      = 0;

  serial_to_parallel_if #(.WIDTH(8)) ifa ();
  serial_to_parallel_if #(.WIDTH(8)) ifb ();

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .clear_n(clear_n), .sync_clear(sc_a), .bus(ifa)
  );
  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .clear_n(clear_n), .sync_clear(sc_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic v);
    ifa.in_bit   = b;
    ifa.in_valid = v;
    ifb.in_bit   = b;
    ifb.in_valid = v;
  endtask

  // Feeds a byte MSB first into both DUTs, one accept per cycle.
  task automatic send_msb(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive(w[7-i], 1'b1);
      tick();
    end
  endtask

  initial begin
    logic [7:0] w;
    int acc;
    logic v;
    drive(1'b0, 1'b0);
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;

    // reset state
    #2;
    check("rst_valid", ifa.out_valid, 0);
    check("rst_count", ifa.bit_count, 0);
    check("rst_data", ifa.out_data, 0);
    check("rst_state", dut_a.state_r, S_IDLE);
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    check("rst_in_ready", ifa.in_ready, 1);
    tick();

    // A5 on both orders, one-cycle valid pulse
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      drive(w[7-i], 1'b1);
      tick();
      if (i == 6) begin
        check("a5_cnt7", ifa.bit_count, 7);
        check("a5_novalid", ifa.out_valid, 0);
      end
    end
    check("a5_valid", ifa.out_valid, 1);
    check("a5_data_msb", ifa.out_data, 32'hA5);
    check("a5_data_lsb", ifb.out_data, 32'hA5);
    check("a5_cnt0", ifa.bit_count, 0);
    check("a5_state", dut_a.state_r, S_IDLE);
    drive(1'b0, 1'b0);
    tick();
    check("a5_pulse", ifa.out_valid, 0);
    check("a5_hold", ifa.out_data, 32'hA5);

    // 1,1,0,0,0,0,0,0 -> 03 LSB first, C0 MSB first
    w = 8'h03;
    for (int i = 0; i < 8; i++) begin
      drive(w[i], 1'b1);
      tick();
    end
    check("w03_lsb", ifb.out_data, 32'h03);
    check("wc0_msb", ifa.out_data, 32'hC0);
    drive(1'b0, 1'b0);
    tick();

    // backpressure: 3C held, 96 stalls on its last bit
    ifa.out_ready = 1'b0;
    send_msb(8'h3C, 8);
    check("bp_valid1", ifa.out_valid, 1);
    check("bp_data1", ifa.out_data, 32'h3C);
    w = 8'h96;
    send_msb(w, 7);
    check("bp_in_ready", ifa.in_ready, 0);
    check("bp_cnt7", ifa.bit_count, 7);
    check("bp_stall", dut_a.state_r, S_STALL);
    drive(w[0], 1'b1);
    tick();
    check("bp_hold_cnt", ifa.bit_count, 7);
    check("bp_hold_data", ifa.out_data, 32'h3C);
    ifa.out_ready = 1'b1;
    tick();
    check("bp_drain", ifa.out_valid, 0);
    check("bp_ready_again", ifa.in_ready, 1);
    check("bp_shift", dut_a.state_r, S_SHIFT);
    check("bp_cnt_kept", ifa.bit_count, 7);
    ifa.out_ready = 1'b0;
    tick();
    check("bp_valid2", ifa.out_valid, 1);
    check("bp_data2", ifa.out_data, 32'h96);
    check("bp_idle", dut_a.state_r, S_IDLE);
    ifa.out_ready = 1'b1;
    drive(1'b0, 1'b0);
    tick();

    // asynchronous reset mid-word, then a clean word
    send_msb(8'hD0, 5);
    check("mid_cnt5", ifa.bit_count, 5);
    drive(1'b0, 1'b0);
    #3;
    clear_n = 1'b0;
    #1;
    check("mid_cnt0", ifa.bit_count, 0);
    check("mid_valid0", ifa.out_valid, 0);
    check("mid_data0", ifa.out_data, 0);
    #2;
    clear_n = 1'b1;
    tick();
    send_msb(8'h5A, 8);
    check("mid_clean", ifa.out_data, 32'h5A);
    check("mid_valid", ifa.out_valid, 1);
    drive(1'b0, 1'b0);
    tick();

    // gappy FF with X on idle cycles
    acc = 0;
    for (int k = 0; k < 64 && acc < 8; k++) begin
      v = ((k % 4) == 0) || ((k % 4) == 3);
      drive(v ? 1'b1 : 1'bx, v);
      tick();
      if (v) acc++;
      check("gap_cnt", ifa.bit_count, 32'(acc % 8));
    end
    check("gap_done", acc, 8);
    check("gap_data", ifa.out_data, 32'hFF);
    check("gap_valid", ifa.out_valid, 1);
    drive(1'b0, 1'b0);
    tick();

    // sync_clear with a pending word and a live input bit
    ifa.out_ready = 1'b0;
    send_msb(8'h81, 8);
    check("sc_pending", ifa.out_valid, 1);
    send_msb(8'hE0, 3);
    check("sc_cnt3", ifa.bit_count, 3);
    sc_a = 1'b1;
    drive(1'b1, 1'b1);
    tick();
    sc_a = 1'b0;
    check("sc_valid0", ifa.out_valid, 0);
    check("sc_cnt0", ifa.bit_count, 0);
    check("sc_data0", ifa.out_data, 0);
    check("sc_state", dut_a.state_r, S_IDLE);
    drive(1'b0, 1'b0);
    tick();
    check("sc_not_counted", ifa.bit_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
